// File: rtl/clock_alarm_pkg.sv
// rtl/clock_alarm_pkg.sv - shared state encoding and time limits for the alarm controller
package clock_alarm_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_e;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

endpackage

// File: rtl/clock_sec_tick.sv
// rtl/clock_sec_tick.sv - one-cycle tick whenever the upstream seconds value changes
module clock_sec_tick #(
   parameter int SEC_W = 6
) (
   input  logic             clk,
   input  logic [SEC_W-1:0] seconds,
   output logic             sec_tick
);

   logic [SEC_W-1:0] seconds_q;

   // Reset also loads the live value, so the load is unconditional and no tick follows reset.
   always_ff @(posedge clk) begin
      seconds_q <= seconds;
   end

   assign sec_tick = (seconds != seconds_q);

endmodule

// File: rtl/clock_alarm.sv
// rtl/clock_alarm.sv - alarm FSM with snooze/stop/timeout; CLOCK_ALARM_BUZZ_PULSE_EN selects pulsed buzzer
module clock_alarm
   import clock_alarm_pkg::*;
#(
   parameter int SEC_W       = 6,
   parameter int MIN_W       = 6,
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 120,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEC_W-1:0] seconds,
   input  logic [MIN_W-1:0] minutes,
   input  logic             set_valid,
   output logic             set_ready,
   input  logic [MIN_W-1:0] set_minutes,
   input  logic             set_arm,
   output logic             set_err,
   input  logic             snooze,
   input  logic             stop,
   output logic [MIN_W-1:0] alarm_min,
   output logic             armed,
   output logic             ringing,
   output logic             snoozing,
   output logic             buzzer,
   output logic [1:0]       snooze_used
);

   localparam int RW = $clog2(RING_SECS + 1);
   localparam int SW = $clog2(SNOOZE_SECS + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);
   localparam logic [1:0]    SNZ_LIMIT = 2'(MAX_SNOOZE);

   alarm_state_e     state, state_n;
   logic [MIN_W-1:0] alarm_min_n;
   logic [1:0]       snooze_used_n;
   logic [RW-1:0]    ring_cnt, ring_cnt_n;
   logic [SW-1:0]    snz_cnt, snz_cnt_n;
   logic             set_err_n;
   logic             sec_tick, match, accept, set_ok;

   clock_sec_tick #(.SEC_W(SEC_W)) u_sec_tick (
      .clk      (clk),
      .seconds  (seconds),
      .sec_tick (sec_tick)
   );

   assign set_ready = (state != RINGING);
   assign accept    = set_valid && set_ready;
   assign set_ok    = (set_minutes <= MIN_W'(MIN_MAX));
   assign match     = sec_tick && (seconds == '0) && (minutes == alarm_min);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= DISARMED;
         alarm_min   <= '0;
         snooze_used <= '0;
         ring_cnt    <= '0;
         snz_cnt     <= '0;
         set_err     <= 1'b0;
      end else begin
         state       <= state_n;
         alarm_min   <= alarm_min_n;
         snooze_used <= snooze_used_n;
         ring_cnt    <= ring_cnt_n;
         snz_cnt     <= snz_cnt_n;
         set_err     <= set_err_n;
      end
   end

   always_comb begin
      state_n       = state;
      alarm_min_n   = alarm_min;
      snooze_used_n = snooze_used;
      ring_cnt_n    = ring_cnt;
      snz_cnt_n     = snz_cnt;
      set_err_n     = 1'b0;
      // A valid setting overrides any same-cycle match and cancels a pending snooze.
      if (accept && set_ok) begin
         alarm_min_n   = set_minutes;
         state_n       = set_arm ? ARMED : DISARMED;
         snooze_used_n = '0;
      end else begin
         set_err_n = accept;
         unique case (state)
            ARMED: begin
               if (match) begin
                  state_n    = RINGING;
                  ring_cnt_n = '0;
               end
            end
            RINGING: begin
               if (stop) begin
                  state_n       = ARMED;
                  snooze_used_n = '0;
               end else if (snooze && (snooze_used < SNZ_LIMIT)) begin
                  state_n       = SNOOZE;
                  snz_cnt_n     = SNZ_LOAD;
                  snooze_used_n = snooze_used + 2'd1;
               end else if (sec_tick) begin
                  if (ring_cnt == RING_LAST) begin
                     state_n       = ARMED;
                     snooze_used_n = '0;
                  end else begin
                     ring_cnt_n = ring_cnt + RW'(1);
                  end
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_n       = ARMED;
                  snooze_used_n = '0;
               end else if (sec_tick) begin
                  if (snz_cnt == SW'(1)) begin
                     state_n    = RINGING;
                     ring_cnt_n = '0;
                  end else begin
                     snz_cnt_n = snz_cnt - SW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign armed    = (state != DISARMED);
   assign ringing  = (state == RINGING);
   assign snoozing = (state == SNOOZE);

`ifdef CLOCK_ALARM_BUZZ_PULSE_EN
   logic buzz_q, buzz_n;

   always_comb begin
      buzz_n = 1'b0;
      if (state_n == RINGING) begin
         if (state != RINGING)
            buzz_n = 1'b1;
         else if (sec_tick)
            buzz_n = ~buzz_q;
         else
            buzz_n = buzz_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         buzz_q <= 1'b0;
      else
         buzz_q <= buzz_n;
   end

   assign buzzer = buzz_q;
`else
   assign buzzer = ringing;
`endif

endmodule
